// File: rtl/rf_wb_scoreboard_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rf_wb_scoreboard_if
// Purpose  : Bundles the decode-issue, dual-writeback and RF write-port
//            signals of the register-file scoreboard.
// Revision : 1.0  initial release
// ============================================================================
interface rf_wb_scoreboard_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    // decode issue side
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] issue_rs1;
    logic          issue_rs1_used;
    logic [AW-1:0] issue_rs2;
    logic          issue_rs2_used;
    logic          stall;

    // writeback source 0 (ALU pipe)
    logic          wb0_valid;
    logic [AW-1:0] wb0_rd;
    logic [DW-1:0] wb0_data;
    logic          wb0_ready;

    // writeback source 1 (load / long-latency unit)
    logic          wb1_valid;
    logic [AW-1:0] wb1_rd;
    logic [DW-1:0] wb1_data;
    logic          wb1_ready;

    // register-file write port
    logic          rf_we;
    logic [AW-1:0] rf_w_add;
    logic [DW-1:0] rf_w_data;

    // pipeline / environment side
    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs1_used,
               issue_rs2, issue_rs2_used,
               wb0_valid, wb0_rd, wb0_data,
               wb1_valid, wb1_rd, wb1_data,
        input  stall, wb0_ready, wb1_ready, rf_we, rf_w_add, rf_w_data
    );

    // scoreboard side
    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs1_used,
               issue_rs2, issue_rs2_used,
               wb0_valid, wb0_rd, wb0_data,
               wb1_valid, wb1_rd, wb1_data,
        output stall, wb0_ready, wb1_ready, rf_we, rf_w_add, rf_w_data
    );
endinterface
`default_nettype wire

// File: rtl/rf_wb_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rf_wb_scoreboard
// Purpose  : Busy-bit scoreboard for a 2R/1W register file. Stalls decode on
//            RAW/WAW hazards and arbitrates two writeback sources (ALU with
//            default priority, load unit with starvation guard) onto the
//            registered RF write port.
// Revision : 1.0  initial release
// ============================================================================
module rf_wb_scoreboard #(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rf_wb_scoreboard_if.slave    bus
);
    localparam int            c_nreg    = 2 ** AW;
    localparam int            c_cnt_w   = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

    logic [c_nreg-1:0]  r_busy;
    logic [c_nreg-1:0]  w_busy_nxt;
    logic [c_cnt_w-1:0] r_starve_cnt;
    logic [c_cnt_w-1:0] w_starve_cnt_nxt;
    logic               r_rf_we;
    logic [AW-1:0]      r_rf_w_add;
    logic [DW-1:0]      r_rf_w_data;

    logic               w_starved;
    logic               w_stall;
    logic               w_issue_acc;
    logic               w_wb0_fire;
    logic               w_wb1_fire;
    logic               w_wb_fire;
    logic [AW-1:0]      w_sel_rd;
    logic [DW-1:0]      w_sel_data;

    // wb1 has lost often enough that it must win this cycle if it asks
    assign w_starved = (r_starve_cnt == c_starve_max);

    // hazard check; busy[0] is never set, so x0 never stalls
    assign w_stall = bus.issue_valid &
                     ((bus.issue_rs1_used & r_busy[bus.issue_rs1]) |
                      (bus.issue_rs2_used & r_busy[bus.issue_rs2]) |
                      r_busy[bus.issue_rd]);
    assign w_issue_acc = bus.issue_valid & ~w_stall;

    // grants are mutually exclusive: wb1_ready needs !wb0_valid or starved,
    // and starved with wb1_valid withdraws wb0_ready
    assign bus.wb0_ready = ~(bus.wb1_valid & w_starved);
    assign bus.wb1_ready = ~bus.wb0_valid | w_starved;
    assign w_wb0_fire    = bus.wb0_valid & bus.wb0_ready;
    assign w_wb1_fire    = bus.wb1_valid & bus.wb1_ready;
    assign w_wb_fire     = w_wb0_fire | w_wb1_fire;
    assign w_sel_rd      = w_wb1_fire ? bus.wb1_rd   : bus.wb0_rd;
    assign w_sel_data    = w_wb1_fire ? bus.wb1_data : bus.wb0_data;

    assign bus.stall     = w_stall;
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_w_add  = r_rf_w_add;
    assign bus.rf_w_data = r_rf_w_data;

    // next busy vector: writeback clears first, issue set afterwards so a
    // new producer of the same register stays pending
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb_fire) begin
            w_busy_nxt[w_sel_rd] = 1'b0;
        end
        if (w_issue_acc && (bus.issue_rd != '0)) begin
            w_busy_nxt[bus.issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // starvation counter: counts wb1 losses, saturating; cleared when wb1
    // wins or stops asking
    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (!bus.wb1_valid || w_wb1_fire) begin
            w_starve_cnt_nxt = '0;
        end else if (!w_starved) begin
            w_starve_cnt_nxt = r_starve_cnt + 1'b1;
        end
    end

    // scoreboard state and registered RF write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= '0;
            r_starve_cnt <= '0;
            r_rf_we      <= 1'b0;
            r_rf_w_add   <= '0;
            r_rf_w_data  <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            r_rf_we      <= w_wb_fire && (w_sel_rd != '0);
            if (w_wb_fire) begin
                r_rf_w_add  <= w_sel_rd;
                r_rf_w_data <= w_sel_data;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_scoreboard
// Purpose  : Self-checking bench for rf_wb_scoreboard: directed hazard,
//            arbitration and reset scenarios plus a randomized run against a
//            behavioural scoreboard model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rf_wb_scoreboard;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int SMAX = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    rf_wb_scoreboard_if #(.AW(AW), .DW(DW)) bus();

    rf_wb_scoreboard #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // behavioural model: set of pending registers, wb1 loss streak, RF port
    bit [31:0]     m_busy;
    int            m_lose;
    logic          m_we;
    logic [AW-1:0] m_add;
    logic [DW-1:0] m_data;
    bit            g0, g1, last_acc;
    logic          obs_stall, obs_r0, obs_r1, exp_stall, exp_r0, exp_r1;

    function automatic void model_reset();
        m_busy = '0; m_lose = 0; m_we = 1'b0; m_add = '0; m_data = '0;
        g0 = 1'b0; g1 = 1'b0; last_acc = 1'b0;
    endfunction

    function automatic bit model_stall();
        return bus.issue_valid &&
               ((bus.issue_rs1_used && m_busy[bus.issue_rs1]) ||
                (bus.issue_rs2_used && m_busy[bus.issue_rs2]) ||
                m_busy[bus.issue_rd]);
    endfunction

    function automatic void model_edge();
        bit            st;
        logic [AW-1:0] rd;
        st = model_stall();
        g1 = bus.wb1_valid && (!bus.wb0_valid || m_lose == SMAX);
        g0 = bus.wb0_valid && !g1;
        last_acc = bus.issue_valid && !st;
        if (g0 || g1) begin
            rd     = g1 ? bus.wb1_rd : bus.wb0_rd;
            m_data = g1 ? bus.wb1_data : bus.wb0_data;
            m_add  = rd;
            m_we   = (rd != 0);
            m_busy[rd] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (last_acc && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
        if (bus.wb1_valid && !g1) m_lose = (m_lose < SMAX) ? m_lose + 1 : SMAX;
        else                      m_lose = 0;
    endfunction

    task automatic idle();
        bus.issue_valid = 0; bus.issue_rd = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
        bus.issue_rs1_used = 0; bus.issue_rs2_used = 0;
        bus.wb0_valid = 0; bus.wb0_rd = '0; bus.wb0_data = '0;
        bus.wb1_valid = 0; bus.wb1_rd = '0; bus.wb1_data = '0;
    endtask

    // one clock: capture combinational outputs mid-cycle, advance the model
    // at the edge, return just after the edge
    task automatic cycle();
        @(negedge clk);
        obs_stall = bus.stall; obs_r0 = bus.wb0_ready; obs_r1 = bus.wb1_ready;
        exp_stall = model_stall();
        exp_r0 = !(bus.wb1_valid && m_lose == SMAX);
        exp_r1 = !bus.wb0_valid || m_lose == SMAX;
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle();
        bus.wb0_valid = 1; bus.wb0_rd = 5'd3; bus.wb0_data = 32'h1234;
        rst_n = 0; model_reset();
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b exp 0", bus.rf_we); end
        n_cmp++; if (bus.rf_w_add !== 5'd0) begin n_err++; $display("FAIL reset_add got %0h exp 0", bus.rf_w_add); end
        n_cmp++; if (bus.rf_w_data !== 32'd0) begin n_err++; $display("FAIL reset_data got %0h exp 0", bus.rf_w_data); end
        bus.issue_valid = 1; bus.issue_rs1_used = 1; bus.issue_rs2_used = 1;
        for (int r = 0; r < 32; r++) begin
            bus.issue_rd = 5'(r); bus.issue_rs1 = 5'(r); bus.issue_rs2 = 5'(31 - r);
            #1;
            n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_busy%0d stall got %b exp 0", r, bus.stall); end
        end
        idle();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL reset_release_we got %b exp 0", bus.rf_we); end
    endtask

    task automatic test_raw();
        idle(); bus.issue_valid = 1; bus.issue_rd = 5'd5;
        cycle();
        n_cmp++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL raw_first_issue stall got %b exp 0", obs_stall); end
        bus.issue_rd = 5'd0; bus.issue_rs1 = 5'd5; bus.issue_rs1_used = 1;
        repeat (2) begin
            cycle();
            n_cmp++; if (obs_stall !== 1'b1) begin n_err++; $display("FAIL raw_wait stall got %b exp 1", obs_stall); end
        end
        bus.wb0_valid = 1; bus.wb0_rd = 5'd5; bus.wb0_data = 32'hA5;
        cycle();
        n_cmp++; if (obs_stall !== 1'b1 || obs_r0 !== 1'b1) begin n_err++; $display("FAIL raw_wb_cycle stall/ready got %b%b exp 11", obs_stall, obs_r0); end
        n_cmp++; if ({bus.rf_we, bus.rf_w_add, bus.rf_w_data} !== {1'b1, 5'd5, 32'hA5}) begin
            n_err++; $display("FAIL raw_write got we=%b add=%0d data=%0h exp we=1 add=5 data=a5", bus.rf_we, bus.rf_w_add, bus.rf_w_data); end
        bus.wb0_valid = 0;
        cycle();
        n_cmp++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL raw_release stall got %b exp 0", obs_stall); end
        n_cmp++; if (bus.rf_we !== 1'b0 || bus.rf_w_add !== 5'd5) begin n_err++; $display("FAIL raw_hold got we=%b add=%0d exp we=0 add=5", bus.rf_we, bus.rf_w_add); end
        idle();
    endtask

    task automatic test_waw();
        idle(); bus.issue_valid = 1; bus.issue_rd = 5'd7;
        cycle();
        cycle();
        n_cmp++; if (obs_stall !== 1'b1) begin n_err++; $display("FAIL waw_stall got %b exp 1", obs_stall); end
        bus.wb1_valid = 1; bus.wb1_rd = 5'd7; bus.wb1_data = 32'h77;
        cycle();
        n_cmp++; if (obs_r1 !== 1'b1 || obs_stall !== 1'b1) begin n_err++; $display("FAIL waw_wb1 ready/stall got %b%b exp 11", obs_r1, obs_stall); end
        n_cmp++; if ({bus.rf_we, bus.rf_w_add, bus.rf_w_data} !== {1'b1, 5'd7, 32'h77}) begin
            n_err++; $display("FAIL waw_write got we=%b add=%0d data=%0h exp 1/7/77", bus.rf_we, bus.rf_w_add, bus.rf_w_data); end
        bus.wb1_valid = 0;
        cycle();
        n_cmp++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL waw_release stall got %b exp 0", obs_stall); end
        idle(); bus.wb0_valid = 1; bus.wb0_rd = 5'd7; bus.wb0_data = 32'h7;
        cycle();
        idle(); cycle();
    endtask

    task automatic test_starvation();
        int n0 = 0, n1 = 0, w10 = 0, w20 = 0;
        bit exp1;
        idle();
        bus.wb0_valid = 1; bus.wb0_rd = 5'd10; bus.wb0_data = 32'h1000_0000;
        bus.wb1_valid = 1; bus.wb1_rd = 5'd20; bus.wb1_data = 32'h2000_0000;
        for (int k = 0; k < 12; k++) begin
            exp1 = (k % 4 == 3);
            cycle();
            n_cmp++; if (obs_r1 !== exp1 || obs_r0 !== !exp1) begin
                n_err++; $display("FAIL starve_grant k=%0d got r0=%b r1=%b exp r0=%b r1=%b", k, obs_r0, obs_r1, !exp1, exp1); end
            n_cmp++; if (bus.rf_w_add !== (exp1 ? 5'd20 : 5'd10) ||
                         bus.rf_w_data !== (exp1 ? 32'h2000_0000 + n1 : 32'h1000_0000 + n0)) begin
                n_err++; $display("FAIL starve_write k=%0d got add=%0d data=%0h", k, bus.rf_w_add, bus.rf_w_data); end
            if (bus.rf_we && bus.rf_w_add == 5'd10) w10++;
            if (bus.rf_we && bus.rf_w_add == 5'd20) w20++;
            if (exp1) begin n1++; bus.wb1_data = 32'h2000_0000 + n1; end
            else      begin n0++; bus.wb0_data = 32'h1000_0000 + n0; end
        end
        n_cmp++; if (w10 !== 9 || w20 !== 3) begin n_err++; $display("FAIL starve_counts got %0d/%0d exp 9/3", w10, w20); end
        idle(); cycle();
    endtask

    task automatic test_x0();
        idle(); bus.issue_valid = 1;
        cycle();
        n_cmp++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL x0_issue stall got %b exp 0", obs_stall); end
        bus.issue_rs1_used = 1; bus.issue_rs2_used = 1;
        cycle();
        n_cmp++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL x0_src stall got %b exp 0", obs_stall); end
        idle(); bus.wb1_valid = 1; bus.wb1_rd = 5'd0; bus.wb1_data = 32'hFFFF;
        cycle();
        n_cmp++; if (obs_r1 !== 1'b1) begin n_err++; $display("FAIL x0_wb1_ready got %b exp 1", obs_r1); end
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL x0_we got %b exp 0", bus.rf_we); end
        idle(); cycle();
    endtask

    task automatic test_collision();
        idle();
        bus.issue_valid = 1; bus.issue_rd = 5'd9;
        bus.wb0_valid = 1; bus.wb0_rd = 5'd9; bus.wb0_data = 32'h99;
        cycle();
        n_cmp++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL coll_issue stall got %b exp 0", obs_stall); end
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_w_add !== 5'd9) begin n_err++; $display("FAIL coll_write got we=%b add=%0d exp 1/9", bus.rf_we, bus.rf_w_add); end
        idle(); bus.issue_valid = 1; bus.issue_rs1 = 5'd9; bus.issue_rs1_used = 1;
        cycle();
        n_cmp++; if (obs_stall !== 1'b1) begin n_err++; $display("FAIL coll_busy9 stall got %b exp 1", obs_stall); end
        // burst interrupted by an asynchronous reset between edges
        idle();
        bus.wb0_valid = 1; bus.wb0_rd = 5'd13; bus.wb0_data = 32'hDEAD_BEEF;
        bus.issue_valid = 1; bus.issue_rd = 5'd14;
        cycle();
        #2; rst_n = 0; #1;
        n_cmp++; if ({bus.rf_we, bus.rf_w_add, bus.rf_w_data} !== {1'b0, 5'd0, 32'd0}) begin
            n_err++; $display("FAIL async_reset got we=%b add=%0d data=%0h exp 0/0/0", bus.rf_we, bus.rf_w_add, bus.rf_w_data); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL async_reset_stall got %b exp 0", bus.stall); end
        model_reset();
        @(posedge clk); #1;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL reset_held_we got %b exp 0", bus.rf_we); end
        idle();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        idle(); g0 = 0; g1 = 0; last_acc = 0;
        for (int c = 0; c < 600; c++) begin
            if (!bus.wb0_valid || g0) begin
                bus.wb0_valid = ($urandom_range(0, 2) != 0);
                bus.wb0_rd = 5'($urandom_range(0, 7)); bus.wb0_data = $urandom();
            end
            if (!bus.wb1_valid || g1) begin
                bus.wb1_valid = ($urandom_range(0, 1) != 0);
                bus.wb1_rd = 5'($urandom_range(0, 7)); bus.wb1_data = $urandom();
            end
            if (!bus.issue_valid || last_acc) begin
                bus.issue_valid = ($urandom_range(0, 1) != 0);
                bus.issue_rd  = 5'($urandom_range(0, 7));
                bus.issue_rs1 = 5'($urandom_range(0, 7));
                bus.issue_rs2 = 5'($urandom_range(0, 7));
                bus.issue_rs1_used = ($urandom_range(0, 1) != 0);
                bus.issue_rs2_used = ($urandom_range(0, 1) != 0);
            end
            cycle();
            n_cmp++; if ({obs_stall, obs_r0, obs_r1} !== {exp_stall, exp_r0, exp_r1}) begin
                n_err++; $display("FAIL rand_comb c=%0d got stall/r0/r1=%b%b%b exp %b%b%b", c, obs_stall, obs_r0, obs_r1, exp_stall, exp_r0, exp_r1); end
            n_cmp++; if ({bus.rf_we, bus.rf_w_add, bus.rf_w_data} !== {m_we, m_add, m_data}) begin
                n_err++; $display("FAIL rand_write c=%0d got %b/%0d/%0h exp %b/%0d/%0h", c, bus.rf_we, bus.rf_w_add, bus.rf_w_data, m_we, m_add, m_data); end
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        test_reset();
        test_raw();
        test_waw();
        test_starvation();
        test_x0();
        test_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
